pwm_duty_ramp: RTL and testbench

//  Soft-start / soft-change stage that sits directly upstream of the PWM controller.

---
 rtl/pwm_duty_ramp.sv | 106 ++++++++++
 tb/tb_pwm_duty_ramp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Duty soft-start stage: latches a requested duty and walks the registered duty output
// one step per prescaler period toward it, so the downstream PWM never sees a jump.
module pwm_duty_ramp #(
    parameter int DUTY_W   = 4,
    parameter int TICK_DIV = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [DUTY_W-1:0] target,
    input  logic              kill,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              at_target
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic              step;
    logic [DUTY_W-1:0] duty_inc, duty_dec;

    assign duty_inc = duty_q + 1'b1;
    assign duty_dec = duty_q - 1'b1;

    // NOTE: every register is updated with <= so all of them sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            presc_q <= presc_d;
        end
    end

    // NOTE: each output of this block gets a hold-value default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        presc_d = presc_q;
        step    = (presc_q == PRESC_LAST);

        if (kill) begin
            duty_d  = '0;
            tgt_d   = '0;
            state_d = IDLE;
            presc_d = '0;
        end else if (load) begin
            // Retarget only; the direction is re-evaluated from the new tgt_q next edge.
            tgt_d   = target;
            presc_d = '0;
        end else if (en) begin
            presc_d = step ? '0 : presc_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (tgt_q > duty_q)      state_d = UP;
                    else if (tgt_q < duty_q) state_d = DOWN;
                end
                UP: begin
                    if (duty_q == tgt_q) begin
                        state_d = IDLE;
                    end else if (duty_q > tgt_q) begin
                        state_d = DOWN;
                    end else if (step) begin
                        // duty_q < tgt_q here, so the increment cannot wrap.
                        duty_d = duty_inc;
                        if (duty_inc == tgt_q) state_d = IDLE;
                    end
                end
                DOWN: begin
                    if (duty_q == tgt_q) begin
                        state_d = IDLE;
                    end else if (duty_q < tgt_q) begin
                        state_d = UP;
                    end else if (step) begin
                        duty_d = duty_dec;
                        if (duty_dec == tgt_q) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign duty      = duty_q;
    assign busy      = (state_q != IDLE);
    assign at_target = (state_q == IDLE) && (duty_q == tgt_q);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: the driver pushes model predictions per edge,
// a monitor pops and compares them against the DUT outputs one time unit after each edge.
module tb_pwm_duty_ramp;

    localparam int DW = 4;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] target = '0;
    logic          kill = 1'b0;
    logic [DW-1:0] duty;
    logic          busy;
    logic          at_target;

    pwm_duty_ramp #(.DUTY_W(DW), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .target    (target),
        .kill      (kill),
        .duty      (duty),
        .busy      (busy),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] duty;
        logic          busy;
        logic          at;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: ramp position, requested target, cycles into the current step
    // period, and the direction of travel (+1 rising, -1 falling, 0 settled).
    int ref_duty = 0;
    int ref_tgt  = 0;
    int ref_cnt  = 0;
    int ref_dir  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        ref_duty = 0;
        ref_tgt  = 0;
        ref_cnt  = 0;
        ref_dir  = 0;
    endtask

    task automatic model_step(input logic k, input logic l, input logic e, input int t);
        int  want;
        bit  stepping;
        if (k) begin
            model_reset();
        end else if (l) begin
            ref_tgt = t;
            ref_cnt = 0;
        end else if (e) begin
            stepping = (ref_cnt == TD - 1);
            ref_cnt  = (ref_cnt + 1) % TD;
            want = (ref_tgt > ref_duty) ? 1 : ((ref_tgt < ref_duty) ? -1 : 0);
            if (want != ref_dir) begin
                // Direction changes (start, reversal, or settle) cost one edge and no step.
                ref_dir = want;
            end else if (ref_dir != 0 && stepping) begin
                ref_duty = ref_duty + ref_dir;
                if (ref_duty == ref_tgt) ref_dir = 0;
            end
        end
    endtask

    // One clock edge: capture the driven inputs, advance the model, queue the prediction.
    task automatic cycle();
        logic k, l, e;
        int   t;
        exp_t x;
        k = kill;
        l = load;
        e = en;
        t = int'(target);
        @(posedge clk);
        model_step(k, l, e, t);
        x.duty = DW'(ref_duty);
        x.busy = (ref_dir != 0);
        x.at   = (ref_dir == 0) && (ref_duty == ref_tgt);
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        load = 1'b0;
        kill = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_target(input int t);
        load   = 1'b1;
        target = DW'(t);
        cycle();
        load   = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_duty", 32'(duty), 32'(e.duty));
                check("sb_busy", 32'(busy), 32'(e.busy));
                check("sb_at_target", 32'(at_target), 32'(e.at));
            end
        end
    end

    initial begin : driver
        int budget;
        repeat (2) @(negedge clk);
        check("reset_duty", 32'(duty), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_at_target", 32'(at_target), 1);
        rst = 1'b1;
        en  = 1'b1;
        model_reset();
        run(2);

        // Ramp 0 -> 5 from a load at edge N.
        load_target(5);
        cycle();
        check("up_busy_n1", 32'(busy), 1);
        run(3);
        check("up_duty_n4", 32'(duty), 1);
        run(16);
        check("up_duty_n20", 32'(duty), 5);
        check("up_busy_n20", 32'(busy), 0);
        check("up_at_n20", 32'(at_target), 1);

        // Ramp down 5 -> 2.
        load_target(2);
        run(12);
        check("down_duty", 32'(duty), 2);
        check("down_at", 32'(at_target), 1);

        // Retarget mid-ramp: heading to 10, reverse at duty 6.
        load_target(10);
        run(16);
        check("retgt_duty6", 32'(duty), 6);
        load_target(3);
        cycle();
        check("retgt_busy", 32'(busy), 1);
        check("retgt_hold", 32'(duty), 6);
        run(3);
        check("retgt_first_down", 32'(duty), 5);
        run(8);
        check("retgt_done", 32'(duty), 3);
        check("retgt_at", 32'(at_target), 1);

        // Kill wins over a simultaneous load at duty 7.
        load_target(12);
        run(16);
        check("kill_pre_duty", 32'(duty), 7);
        kill   = 1'b1;
        load   = 1'b1;
        target = 4'd12;
        cycle();
        kill = 1'b0;
        load = 1'b0;
        check("kill_duty", 32'(duty), 0);
        check("kill_busy", 32'(busy), 0);
        check("kill_at", 32'(at_target), 1);

        // Freeze with en=0 mid-ramp, then resume with the remaining prescaler count.
        load_target(8);
        run(10);
        check("frz_pre", 32'(duty), 2);
        en = 1'b0;
        run(20);
        check("frz_hold", 32'(duty), 2);
        check("frz_busy", 32'(busy), 1);
        en = 1'b1;
        run(1);
        check("frz_resume1", 32'(duty), 2);
        run(1);
        check("frz_resume2", 32'(duty), 3);

        // Asynchronous reset between edges, then a full ramp to the top without wrapping.
        load_target(9);
        run(6);
        #2;
        rst = 1'b0;
        #1;
        check("arst_duty", 32'(duty), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_at", 32'(at_target), 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        load_target(15);
        run(15 * TD + 6);
        check("full_duty", 32'(duty), 15);
        check("full_at", 32'(at_target), 1);
        run(3 * TD);
        check("full_nowrap", 32'(duty), 15);

        // Randomized traffic with occasional freezes, retargets and kills.
        for (int i = 0; i < 1500; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 11) == 0);
            kill   = ($urandom_range(0, 59) == 0);
            target = DW'($urandom_range(0, 15));
            cycle();
        end
        run(2);

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
